// File: rtl/lms_anc_seq.sv
// lms_anc_seq: sequential sign-data LMS noise canceller, one shared multiplier.
// Define LMS_LEAKAGE_EN to build the leaky-LMS weight update.
module lms_anc_seq #(
  parameter int TAPS       = 16,
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 32,
  parameter int FRAC_W     = 16,
  parameter int ACC_W      = 40,
  parameter int LEAK_SHIFT = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] ref_in,
  input  logic signed [DATA_W-1:0] pri_in,
  input  logic                     adapt_en,
  input  logic [3:0]               mu_shift,
  input  logic                     weights_clr,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] err_out,
  output logic signed [DATA_W-1:0] est_out
);

  localparam int IW  = $clog2(TAPS);
  localparam int PW  = COEF_W + DATA_W;
  localparam int SW  = COEF_W + 2;
  localparam int LSH = FRAC_W - DATA_W + 1;
`ifdef LMS_LEAKAGE_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  localparam logic signed [DATA_W-1:0] D_HI = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_LO = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  A_HI = ACC_W'(D_HI);
  localparam logic signed [ACC_W-1:0]  A_LO = ACC_W'(D_LO);
  localparam logic signed [SW-1:0] C_HI = {3'b000, {(COEF_W-1){1'b1}}};
  localparam logic signed [SW-1:0] C_LO = {3'b111, {(COEF_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ERR, UPD} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  d_q, d_d;
  logic                      adapt_q, adapt_d;
  logic [3:0]                mu_q, mu_d;
  logic signed [DATA_W-1:0]  x_q [TAPS];
  logic signed [DATA_W-1:0]  x_d [TAPS];
  logic signed [COEF_W-1:0]  w_q [TAPS];
  logic signed [COEF_W-1:0]  w_d [TAPS];
  logic                      out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]  err_q, err_d;
  logic signed [DATA_W-1:0]  est_q, est_d;

  logic signed [COEF_W-1:0]  w_sel;
  logic signed [DATA_W-1:0]  x_sel;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   acc_add;
  logic signed [DATA_W-1:0]  y;
  logic [DATA_W:0]           e_raw;
  logic signed [DATA_W-1:0]  e;
  logic signed [COEF_W-1:0]  e_ext, e_shl, delta;
  logic signed [SW-1:0]      w_sum;
  logic signed [COEF_W-1:0]  w_new;

  // The one multiplier, shared by all taps through the index mux.
  assign w_sel   = w_q[idx_q];
  assign x_sel   = x_q[idx_q];
  assign prod    = PW'(w_sel) * PW'(x_sel);
  assign acc_add = ACC_W'(prod >>> FRAC_W);

  always_comb begin
    y = acc_q[DATA_W-1:0];
    if (acc_q > A_HI)      y = D_HI;
    else if (acc_q < A_LO) y = D_LO;
  end

  assign e_raw = {d_q[DATA_W-1], d_q} - {y[DATA_W-1], y};
  assign e = (e_raw[DATA_W] != e_raw[DATA_W-1]) ?
             (e_raw[DATA_W] ? D_LO : D_HI) : e_raw[DATA_W-1:0];

  // err_q holds e throughout UPD, so the step is derived from it.
  assign e_ext = COEF_W'(err_q);
  assign e_shl = e_ext <<< LSH;
  assign delta = e_shl >>> mu_q;

  always_comb begin
    w_sum = SW'(w_sel);
    if (LEAK_ON) w_sum = w_sum - SW'(w_sel >>> LEAK_SHIFT);
    if (x_sel != '0) begin
      if (x_sel[DATA_W-1]) w_sum = w_sum - SW'(delta);
      else                 w_sum = w_sum + SW'(delta);
    end
    w_new = w_sum[COEF_W-1:0];
    if (w_sum > C_HI)      w_new = C_HI[COEF_W-1:0];
    else if (w_sum < C_LO) w_new = C_LO[COEF_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    d_d         = d_q;
    adapt_d     = adapt_q;
    mu_d        = mu_q;
    x_d         = x_q;
    w_d         = w_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    est_d       = est_q;
    if (weights_clr) begin
      state_d = IDLE;
      idx_d   = '0;
      acc_d   = '0;
      for (int i = 0; i < TAPS; i++) begin
        x_d[i] = '0;
        w_d[i] = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) x_d[k] = x_q[k-1];
            x_d[0]  = ref_in;
            d_d     = pri_in;
            adapt_d = adapt_en;
            mu_d    = mu_shift;
            acc_d   = '0;
            idx_d   = '0;
            state_d = MAC;
          end
        end
        MAC: begin
          acc_d = acc_q + acc_add;
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(TAPS - 1)) begin
            idx_d   = '0;
            state_d = ERR;
          end
        end
        ERR: begin
          est_d       = y;
          err_d       = e;
          out_valid_d = 1'b1;
          state_d     = UPD;
        end
        UPD: begin
          if (adapt_q) w_d[idx_q] = w_new;
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(TAPS - 1)) begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      d_q         <= '0;
      adapt_q     <= 1'b0;
      mu_q        <= '0;
      out_valid_q <= 1'b0;
      err_q       <= '0;
      est_q       <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      d_q         <= d_d;
      adapt_q     <= adapt_d;
      mu_q        <= mu_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      est_q       <= est_d;
      x_q         <= x_d;
      w_q         <= w_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign err_out   = err_q;
  assign est_out   = est_q;

endmodule

// File: tb/tb_lms_anc_seq.sv
// tb_lms_anc_seq: vector table, hand sequences and random samples for lms_anc_seq.
// A sample-level LMS model feeds a scoreboard checked on every out_valid.
module tb_lms_anc_seq;
  localparam int TAPS = 4;
  localparam int DW = 16;
  localparam int CW = 32;
  localparam int FW = 16;
  localparam int AW = 40;
  localparam int NCYC = 2 * TAPS + 2;
`ifdef LMS_LEAKAGE_EN
  localparam bit LEAK = 1'b1;
  localparam int EST7 = 4092;
`else
  localparam bit LEAK = 1'b0;
  localparam int EST7 = 4096;
`endif

  logic clk;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic signed [DW-1:0] ref_in;
  logic signed [DW-1:0] pri_in;
  logic adapt_en;
  logic [3:0] mu_shift;
  logic weights_clr;
  logic out_valid;
  logic signed [DW-1:0] err_out;
  logic signed [DW-1:0] est_out;

  lms_anc_seq #(
    .TAPS(TAPS), .DATA_W(DW), .COEF_W(CW),
    .FRAC_W(FW), .ACC_W(AW), .LEAK_SHIFT(10)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .ref_in(ref_in), .pri_in(pri_in),
    .adapt_en(adapt_en), .mu_shift(mu_shift),
    .weights_clr(weights_clr),
    .out_valid(out_valid),
    .err_out(err_out), .est_out(est_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Sample-level reference model
  longint mw [TAPS];
  longint mx [TAPS];
  longint exp_e_q[$];
  longint exp_y_q[$];

  function automatic longint sat(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      mw[k] = 0;
      mx[k] = 0;
    end
  endtask

  task automatic model_step(input longint r, input longint p, input bit ad,
                            input int mu, output longint y, output longint e);
    longint acc, dl, nw;
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = r;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += (mw[k] * mx[k]) >>> FW;
    y = sat(acc, DW);
    e = sat(p - y, DW);
    if (ad) begin
      dl = (e * (longint'(1) <<< (FW - DW + 1))) >>> mu;
      for (int k = 0; k < TAPS; k++) begin
        nw = mw[k];
        if (LEAK) nw = nw - (mw[k] >>> 10);
        if (mx[k] > 0) nw = nw + dl;
        else if (mx[k] < 0) nw = nw - dl;
        mw[k] = sat(nw, CW);
      end
    end
  endtask

  always @(negedge clk) begin
    longint y, e, ey, ee;
    if (out_valid) begin
      if (exp_e_q.size() == 0) begin
        check("sb_unexpected_out_valid", 1, 0);
      end else begin
        ee = exp_e_q.pop_front();
        ey = exp_y_q.pop_front();
        check("sb_err", err_out, ee);
        check("sb_est", est_out, ey);
      end
    end
    if (reset || weights_clr) begin
      model_clear();
      exp_e_q.delete();
      exp_y_q.delete();
    end else if (in_valid && in_ready) begin
      model_step(ref_in, pri_in, adapt_en, int'(mu_shift), y, e);
      exp_e_q.push_back(e);
      exp_y_q.push_back(y);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    weights_clr = 1'b1;
    tick();
    weights_clr = 1'b0;
  endtask

  task automatic send(input int r, input int p, input bit ad, input int mu,
                      output longint ge, output longint gy,
                      output int ovc, output int ovn, output int rdy);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check("wait_ready", in_ready, 1);
    ref_in = DW'(r);
    pri_in = DW'(p);
    adapt_en = ad;
    mu_shift = 4'(mu);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ovn = 0; ovc = 0; rdy = 0; ge = 0; gy = 0;
    for (int c = 1; c <= NCYC; c++) begin
      if (out_valid) begin
        ovn++;
        ovc = c;
        ge = err_out;
        gy = est_out;
      end
      if (in_ready && rdy == 0) rdy = c;
      if (c < NCYC) tick();
    end
  endtask

  typedef struct {
    bit clr;
    int r;
    int p;
    bit ad;
    int mu;
    int e;
    int y;
  } vec_t;

  vec_t tbl [8];

  initial begin
    longint ge, gy, old_e;
    int ovc, ovn, rdy, nov;
    int acc_c[$];
    int d1, d2;

    tbl[0] = '{1'b0, 1000, 5000, 1'b0, 0, 5000, 0};
    tbl[1] = '{1'b1, 100, 16384, 1'b1, 1, 16384, 0};
    tbl[2] = '{1'b0, 16384, 0, 1'b1, 1, -4096, 4096};
    tbl[3] = '{1'b1, 100, 16384, 1'b1, 1, 16384, 0};
    tbl[4] = '{1'b0, 16384, -32768, 1'b1, 1, -32768, 4096};
    tbl[5] = '{1'b1, 100, 16384, 1'b1, 1, 16384, 0};
    tbl[6] = '{1'b0, 0, 0, 1'b1, 1, 0, 0};
    tbl[7] = '{1'b0, 16384, 0, 1'b0, 1, -EST7, EST7};

    reset = 1'b1;
    in_valid = 1'b0;
    ref_in = '0;
    pri_in = '0;
    adapt_en = 1'b0;
    mu_shift = '0;
    weights_clr = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_out", err_out, 0);
    check("rst_est_out", est_out, 0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].clr) clr_pulse();
      send(tbl[i].r, tbl[i].p, tbl[i].ad, tbl[i].mu, ge, gy, ovc, ovn, rdy);
      check($sformatf("vec%0d_err", i), ge, tbl[i].e);
      check($sformatf("vec%0d_est", i), gy, tbl[i].y);
      check($sformatf("vec%0d_ov_cycle", i), ovc, TAPS + 2);
      check($sformatf("vec%0d_ov_count", i), ovn, 1);
      check($sformatf("vec%0d_ready_cycle", i), rdy, NCYC);
    end

    // in_valid held high: one accept per NCYC cycles
    adapt_en = 1'b1;
    mu_shift = 4'd3;
    in_valid = 1'b1;
    for (int c = 0; c <= 2 * NCYC; c++) begin
      ref_in = DW'($urandom);
      pri_in = DW'($urandom);
      if (in_ready) acc_c.push_back(c);
      tick();
    end
    in_valid = 1'b0;
    d1 = -1;
    d2 = -1;
    if (acc_c.size() >= 3) begin
      d1 = acc_c[1] - acc_c[0];
      d2 = acc_c[2] - acc_c[1];
    end
    check("hold_accepts", acc_c.size(), 3);
    check("hold_gap1", d1, NCYC);
    check("hold_gap2", d2, NCYC);
    repeat (NCYC + 2) tick();

    // weights_clr beats in_valid in the same cycle
    in_valid = 1'b1;
    weights_clr = 1'b1;
    tick();
    in_valid = 1'b0;
    weights_clr = 1'b0;
    check("clr_prio_ready", in_ready, 1);
    nov = 0;
    for (int c = 0; c < NCYC; c++) begin
      if (out_valid) nov++;
      tick();
    end
    check("clr_prio_no_out", nov, 0);

    // weights_clr mid-flight at T+3
    old_e = err_out;
    ref_in = 16'sd1234;
    pri_in = -16'sd2000;
    adapt_en = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    weights_clr = 1'b1;
    tick();
    weights_clr = 1'b0;
    check("clr_mid_ready", in_ready, 1);
    nov = 0;
    for (int c = 0; c < NCYC + 2; c++) begin
      if (out_valid) nov++;
      tick();
    end
    check("clr_mid_no_out", nov, 0);
    check("clr_mid_err_kept", err_out, old_e);
    send(1000, 5000, 1'b0, 0, ge, gy, ovc, ovn, rdy);
    check("clr_after_err", ge, 5000);
    check("clr_after_est", gy, 0);

    // reset mid-flight at T+3
    ref_in = 16'sd300;
    pri_in = 16'sd700;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_err", err_out, 0);
    check("rst_mid_est", est_out, 0);
    nov = 0;
    for (int c = 0; c < NCYC + 2; c++) begin
      if (out_valid) nov++;
      tick();
    end
    check("rst_mid_no_out", nov, 0);

    // Random samples against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) clr_pulse();
      send(int'($signed(DW'($urandom))), int'($signed(DW'($urandom))),
           1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
           ge, gy, ovc, ovn, rdy);
      check($sformatf("rnd%0d_ov_cycle", i), ovc, TAPS + 2);
      check($sformatf("rnd%0d_ov_count", i), ovn, 1);
      check($sformatf("rnd%0d_ready_cycle", i), rdy, NCYC);
    end

    repeat (3) tick();
    check("sb_drained", exp_e_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
